// File: rtl/mc_control_fsm_if.sv
// ---------------------------------------------------------------------------
// mc_control_fsm_if : opcode/handshake inputs and datapath controls of the FSM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mc_control_fsm_if;
   logic [5:0] Opcode;
   logic       MemReady;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       MemtoReg;
   logic       RegDst;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] PCSource;
   logic       Retired;
   logic       Illegal;
   logic       Timeout;
   logic [3:0] State;

   modport master (
      input  Opcode, MemReady,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Retired,
             Illegal, Timeout, State
   );

   modport slave (
      output Opcode, MemReady,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Retired,
             Illegal, Timeout, State
   );
endinterface

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm : multi-cycle main control FSM (fetch/decode/exec/mem/wb)
// Optional addi support when MC_ADDI_EN is defined.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mc_control_fsm #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  wire logic          clk,
   input  wire logic          reset,
   mc_control_fsm_if.master   bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      RTYPE_EX = 4'd6,
      RTYPE_WB = 4'd7,
      BEQ_EX   = 4'd8,
      JUMP_EX  = 4'd9,
      ADDI_EX  = 4'd10,
      ADDI_WB  = 4'd11,
      TRAP     = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       illegal_q, illegal_d;
   logic       timeout_q, timeout_d;

   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, retired;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic       wait_expired;
   logic [8:0] cnt_inc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FETCH;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
      end
   end

   // A wait state expires on the cycle its stall count would reach the limit.
   assign cnt_inc      = {1'b0, cnt_q} + 9'd1;
   assign wait_expired = (TIMEOUT_LIM != 9'd0) && (cnt_inc == TIMEOUT_LIM);

   always_comb begin
      state_d       = state_q;
      cnt_d         = '0;
      illegal_d     = illegal_q;
      timeout_d     = timeout_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      retired       = 1'b0;

      case (state_q)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = bus.MemReady;
            pc_write  = bus.MemReady;
            if (bus.MemReady) begin
               state_d = DECODE;
            end else if (wait_expired) begin
               state_d   = TRAP;
               timeout_d = 1'b1;
            end else begin
               cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_inc[7:0];
            end
         end
         DECODE: begin
            alu_src_b = 2'b11;
            case (bus.Opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = RTYPE_EX;
               OP_BEQ:       state_d = BEQ_EX;
               OP_J:         state_d = JUMP_EX;
`ifdef MC_ADDI_EN
               OP_ADDI:      state_d = ADDI_EX;
`else
               OP_ADDI: begin
                  state_d   = TRAP;
                  illegal_d = 1'b1;
               end
`endif
               default: begin
                  state_d   = TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (bus.Opcode == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD, MEMWR: begin
            i_or_d    = 1'b1;
            mem_read  = (state_q == MEMRD);
            mem_write = (state_q == MEMWR);
            retired   = (state_q == MEMWR) && bus.MemReady;
            if (bus.MemReady) begin
               state_d = (state_q == MEMRD) ? MEMWB : FETCH;
            end else if (wait_expired) begin
               state_d   = TRAP;
               timeout_d = 1'b1;
            end else begin
               cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_inc[7:0];
            end
         end
         MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            retired    = 1'b1;
            state_d    = FETCH;
         end
         RTYPE_EX: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = RTYPE_WB;
         end
         RTYPE_WB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            retired   = 1'b1;
            state_d   = FETCH;
         end
         BEQ_EX: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            retired       = 1'b1;
            state_d       = FETCH;
         end
         JUMP_EX: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            retired   = 1'b1;
            state_d   = FETCH;
         end
`ifdef MC_ADDI_EN
         ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = ADDI_WB;
         end
         ADDI_WB: begin
            reg_write = 1'b1;
            retired   = 1'b1;
            state_d   = FETCH;
         end
`endif
         TRAP: state_d = TRAP;
         default: state_d = FETCH;
      endcase

      // Nothing may strobe the datapath while reset is asserted.
      if (reset) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         i_or_d        = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         mem_to_reg    = 1'b0;
         reg_dst       = 1'b0;
         reg_write     = 1'b0;
         alu_src_a     = 1'b0;
         alu_src_b     = 2'b00;
         alu_op        = 2'b00;
         pc_source     = 2'b00;
         retired       = 1'b0;
      end
   end

   assign bus.PCWrite     = pc_write;
   assign bus.PCWriteCond = pc_write_cond;
   assign bus.IorD        = i_or_d;
   assign bus.MemRead     = mem_read;
   assign bus.MemWrite    = mem_write;
   assign bus.IRWrite     = ir_write;
   assign bus.MemtoReg    = mem_to_reg;
   assign bus.RegDst      = reg_dst;
   assign bus.RegWrite    = reg_write;
   assign bus.ALUSrcA     = alu_src_a;
   assign bus.ALUSrcB     = alu_src_b;
   assign bus.ALUOp       = alu_op;
   assign bus.PCSource    = pc_source;
   assign bus.Retired     = retired;
   assign bus.Illegal     = illegal_q;
   assign bus.Timeout     = timeout_q;
   assign bus.State       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm : directed + random stimulus against an instruction-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mc_control_fsm;
   localparam int unsigned TB_TIMEOUT = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mc_control_fsm_if bus ();

   mc_control_fsm #(.MEM_TIMEOUT(TB_TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Instruction-level model: per-opcode state sequence plus a stall counter.
   int         m_state = -1;
   int         m_idx   = 0;
   int         m_waits = 0;
   bit         m_ill   = 1'b0;
   bit         m_to    = 1'b0;
   logic [5:0] m_op    = 6'd0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic bit op_legal(input logic [5:0] op);
      case (op)
         6'd0, 6'd35, 6'd43, 6'd4, 6'd2: return 1'b1;
`ifdef MC_ADDI_EN
         6'd8: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic int seq_at(input logic [5:0] op, input int idx);
      int s[$];
      case (op)
         6'd0:    s = '{0, 1, 6, 7};
         6'd35:   s = '{0, 1, 2, 3, 4};
         6'd43:   s = '{0, 1, 2, 5};
         6'd4:    s = '{0, 1, 8};
         6'd2:    s = '{0, 1, 9};
         6'd8:    s = '{0, 1, 10, 11};
         default: s = '{0, 1};
      endcase
      return (idx < s.size()) ? s[idx] : -1;
   endfunction

   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
   //  RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,Retired}
   function automatic logic [16:0] exp_out(input int st, input bit mr, input bit rst);
      logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
      logic m2r = 0, rdst = 0, rw = 0, asa = 0, ret = 0;
      logic [1:0] asb = 0, aop = 0, psrc = 0;
      case (st)
         0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
         1:  asb = 2'b11;
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin mrd = 1; iord = 1; end
         4:  begin m2r = 1; rw = 1; ret = 1; end
         5:  begin mwr = 1; iord = 1; ret = mr; end
         6:  begin asa = 1; aop = 2'b10; end
         7:  begin rdst = 1; rw = 1; ret = 1; end
         8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; ret = 1; end
         9:  begin pcw = 1; psrc = 2'b10; ret = 1; end
         10: begin asa = 1; asb = 2'b10; end
         11: begin rw = 1; ret = 1; end
         default: ;
      endcase
      if (rst) return '0;
      return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, ret};
   endfunction

   task automatic model_next(input bit rst, input logic [5:0] op, input bit mr);
      int nxt;
      if (rst) begin
         m_state = 0; m_idx = 0; m_waits = 0; m_ill = 0; m_to = 0;
         return;
      end
      if (m_state == 15) return;
      if ((m_state == 0 || m_state == 3 || m_state == 5) && !mr) begin
         if (TB_TIMEOUT != 0 && m_waits + 1 == int'(TB_TIMEOUT)) begin
            m_state = 15; m_to = 1;
         end else begin
            m_waits++;
         end
         return;
      end
      m_waits = 0;
      if (m_state == 1) begin
         if (!op_legal(op)) begin
            m_state = 15; m_ill = 1;
            return;
         end
         m_op = op;
      end
      m_idx++;
      nxt = seq_at(m_op, m_idx);
      if (nxt < 0) begin
         m_state = 0; m_idx = 0;
      end else begin
         m_state = nxt;
      end
   endtask

   task automatic step(input bit rst, input logic [5:0] op, input bit mr);
      logic [16:0] obs;
      @(negedge clk);
      reset        = rst;
      bus.Opcode   = op;
      bus.MemReady = mr;
      #1;
      obs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
             bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
             bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.Retired};
      check_val("strobes", 32'(obs), 32'(exp_out(m_state, mr, rst)));
      check_val("rd_wr_excl", 32'(bus.MemRead & bus.MemWrite), 32'd0);
      if (m_state >= 0) begin
         check_val("state", 32'(bus.State), 32'(m_state));
         check_val("flags", 32'({bus.Illegal, bus.Timeout}), 32'({m_ill, m_to}));
      end
      model_next(rst, op, mr);
   endtask

   logic [5:0] cur_op;
   int         trap_cycles;
   logic [5:0] ops[7] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8, 6'd63};

   initial begin
      reset        = 1'b1;
      bus.Opcode   = 6'd0;
      bus.MemReady = 1'b0;

      repeat (2) step(1, 6'd0, 1);
      repeat (4) step(0, 6'd0, 1);                  // R-type
      repeat (3) step(0, 6'd35, 1);                 // lw with 3 stalls in MEMRD
      repeat (3) step(0, 6'd35, 0);
      repeat (2) step(0, 6'd35, 1);
      repeat (3) step(0, 6'd4, 1);                  // beq
      repeat (3) step(0, 6'd2, 1);                  // j
      repeat (4) step(0, 6'd43, 1);                 // sw
      repeat (4) step(0, 6'd8, 1);                  // addi (or trap)
      step(1, 6'd0, 1);
      repeat (22) step(0, 6'd63, 1);                // illegal opcode, sit in TRAP
      step(1, 6'd0, 1);
      repeat (6) step(0, 6'd0, 0);                  // fetch timeout
      step(1, 6'd0, 1);
      repeat (3) step(0, 6'd0, 0);                  // ready on 4th wait cycle
      repeat (4) step(0, 6'd0, 1);
      repeat (2) step(0, 6'd43, 1);                 // sw store timeout
      repeat (5) step(0, 6'd43, 0);
      step(1, 6'd0, 1);

      cur_op      = 6'd0;
      trap_cycles = 0;
      for (int i = 0; i < 3000; i++) begin
         bit rst_r, mr_r;
         if (m_state == 0 || m_state == 15) cur_op = ops[$urandom_range(0, 6)];
         if (m_state == 15) trap_cycles++;
         else trap_cycles = 0;
         rst_r = ($urandom_range(0, 199) == 0) || (trap_cycles > 5);
         mr_r  = ($urandom_range(0, 3) != 0);
         step(rst_r, cur_op, mr_r);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
